// File: rtl/pc_next_seq.sv
// rtl/pc_next_seq.sv - registered next-PC sequencer with flag forwarding, jump-through-memory wait and flush window
module pc_next_seq #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flag_we,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              brn,
    input  logic              brz,
    input  logic              j,
    input  logic              jm,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        pc_src,
    output logic              flush,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_JM_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam int             CNT_W     = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam bit             HAS_FLUSH = (FLUSH_CYCLES > 0);

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_TGT = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        pc_src_q;
    logic              flush_q;
    logic              busy_q;
    logic              err_q;
    logic              n_q;
    logic              z_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              n_eff;
    logic              z_eff;
    logic [2:0]        ctl_cnt;
    logic              illegal;
    logic              taken;
    logic [ADDR_W-1:0] pc_inc;

    // Flags written this cycle are forwarded so a branch can use the ALU result directly.
    assign n_eff   = flag_we ? alu_n : n_q;
    assign z_eff   = flag_we ? alu_z : z_q;
    assign ctl_cnt = {2'b00, brn} + {2'b00, brz} + {2'b00, j} + {2'b00, jm};
    assign illegal = (ctl_cnt > 3'd1);
    assign taken   = (ctl_cnt == 3'd1) && ((brn & n_eff) | (brz & z_eff) | j);
    assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            pc_src_q <= SRC_SEQ;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (flag_we) begin
                n_q <= alu_n;
                z_q <= alu_z;
            end
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        if (illegal) begin
                            err_q    <= 1'b1;
                            pc_q     <= pc_inc;
                            pc_src_q <= SRC_SEQ;
                        end else if (jm) begin
                            busy_q  <= 1'b1;
                            state_q <= ST_JM_WAIT;
                        end else if (taken) begin
                            pc_q     <= target;
                            pc_src_q <= SRC_TGT;
                            if (HAS_FLUSH) begin
                                flush_q <= 1'b1;
                                cnt_q   <= CNT_INIT;
                                state_q <= ST_FLUSH;
                            end
                        end else begin
                            pc_q     <= pc_inc;
                            pc_src_q <= SRC_SEQ;
                        end
                    end
                end
                ST_JM_WAIT: begin
                    // Memory target latency is unbounded; only reset leaves this state otherwise.
                    if (mem_valid) begin
                        pc_q     <= mem_rdata;
                        pc_src_q <= SRC_MEM;
                        busy_q   <= 1'b0;
                        if (HAS_FLUSH) begin
                            flush_q <= 1'b1;
                            cnt_q   <= CNT_INIT;
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!stall) begin
                        pc_q     <= pc_inc;
                        pc_src_q <= SRC_SEQ;
                        cnt_q    <= cnt_q - CNT_LAST;
                        if (cnt_q == CNT_LAST) begin
                            flush_q <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc     = pc_q;
    assign pc_src = pc_src_q;
    assign flush  = flush_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_pc_next_seq.sv
// tb/tb_pc_next_seq.sv - directed self-checking bench for pc_next_seq
module tb_pc_next_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flag_we, alu_n, alu_z, brn, brz, j, jm, mem_valid;
    logic [31:0] target, mem_rdata;
    logic [31:0] pc, pc0;
    logic [1:0]  pc_src, pc_src0;
    logic        flush, busy, err, flush0, busy0, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_next_seq #(.ADDR_W(32), .RESET_PC(32'h100), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
        .alu_n(alu_n), .alu_z(alu_z), .brn(brn), .brz(brz), .j(j), .jm(jm),
        .target(target), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .pc(pc), .pc_src(pc_src), .flush(flush), .busy(busy), .err(err)
    );

    pc_next_seq #(.ADDR_W(32), .RESET_PC(32'h100), .FLUSH_CYCLES(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
        .alu_n(alu_n), .alu_z(alu_z), .brn(brn), .brz(brz), .j(j), .jm(jm),
        .target(target), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .pc(pc0), .pc_src(pc_src0), .flush(flush0), .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flag_we = 0; alu_n = 0; alu_z = 0;
        brn = 0; brz = 0; j = 0; jm = 0; mem_valid = 0;
        target = '0; mem_rdata = '0;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic [1:0] e_src,
                                input logic e_flush, input logic e_busy);
        check({tag, " pc"},     pc,              e_pc);
        check({tag, " pc_src"}, {30'd0, pc_src}, {30'd0, e_src});
        check({tag, " flush"},  {31'd0, flush},  {31'd0, e_flush});
        check({tag, " busy"},   {31'd0, busy},   {31'd0, e_busy});
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        expect_state("reset", 32'h100, 2'd0, 1'b0, 1'b0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset nf pc", pc0, 32'h100);
        rst_n = 1;

        // 1: sequential from RESET_PC
        check("t1 pc0", pc, 32'h100);
        tick(); expect_state("t1 c1", 32'h101, 2'd0, 1'b0, 1'b0);
        tick(); expect_state("t1 c2", 32'h102, 2'd0, 1'b0, 1'b0);
        tick(); expect_state("t1 c3", 32'h103, 2'd0, 1'b0, 1'b0);

        // 2: brz with forwarded alu_z, flush window ignores brn
        flag_we = 1; alu_z = 1; brz = 1; target = 32'h40;
        tick(); expect_state("t2 redirect", 32'h40, 2'd1, 1'b1, 1'b0);
        idle(); flag_we = 1; alu_n = 1; brn = 1; target = 32'h80;
        tick(); expect_state("t2 flush1", 32'h41, 2'd0, 1'b1, 1'b0);
        flag_we = 0; alu_n = 0;
        tick(); expect_state("t2 flush_end", 32'h42, 2'd0, 1'b0, 1'b0);
        idle(); flag_we = 1;
        tick(); expect_state("t2 clrflags", 32'h43, 2'd0, 1'b0, 1'b0);
        idle();

        // 3: jump through memory
        jm = 1;
        tick(); expect_state("t3 wait0", 32'h43, 2'd0, 1'b0, 1'b1);
        idle(); stall = 1; j = 1; target = 32'h999;
        tick(); expect_state("t3 wait1", 32'h43, 2'd0, 1'b0, 1'b1);
        idle();
        tick(); expect_state("t3 wait2", 32'h43, 2'd0, 1'b0, 1'b1);
        tick(); expect_state("t3 wait3", 32'h43, 2'd0, 1'b0, 1'b1);
        mem_valid = 1; mem_rdata = 32'hDEAD0000;
        tick(); expect_state("t3 load", 32'hDEAD0000, 2'd2, 1'b1, 1'b0);
        idle();
        tick(); expect_state("t3 flush1", 32'hDEAD0001, 2'd0, 1'b1, 1'b0);
        tick(); expect_state("t3 flush_end", 32'hDEAD0002, 2'd0, 1'b0, 1'b0);

        // 4: brn not taken, then forwarded N taken, stall inside flush
        brn = 1; target = 32'h300;
        tick(); expect_state("t4 brn_nt", 32'hDEAD0003, 2'd0, 1'b0, 1'b0);
        flag_we = 1; alu_n = 1; target = 32'h200;
        tick(); expect_state("t4 brn_fwd", 32'h200, 2'd1, 1'b1, 1'b0);
        idle(); stall = 1;
        tick(); expect_state("t4 stall1", 32'h200, 2'd1, 1'b1, 1'b0);
        tick(); expect_state("t4 stall2", 32'h200, 2'd1, 1'b1, 1'b0);
        stall = 0;
        tick(); expect_state("t4 flush1", 32'h201, 2'd0, 1'b1, 1'b0);
        tick(); expect_state("t4 flush_end", 32'h202, 2'd0, 1'b0, 1'b0);
        brn = 1; target = 32'h300;
        tick(); expect_state("t4 brn_reg", 32'h300, 2'd1, 1'b1, 1'b0);
        idle();
        tick(); tick(); expect_state("t4 after", 32'h302, 2'd0, 1'b0, 1'b0);
        stall = 1; j = 1; target = 32'h500;
        tick(); expect_state("t4 run_stall", 32'h302, 2'd0, 1'b0, 1'b0);
        idle();

        // 5: wrap through all-ones, illegal control
        j = 1; target = 32'hFFFFFFFF;
        tick(); expect_state("t5 to_max", 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0);
        idle();
        tick(); expect_state("t5 wrap", 32'h0, 2'd0, 1'b1, 1'b0);
        tick(); expect_state("t5 wrap1", 32'h1, 2'd0, 1'b0, 1'b0);
        check("t5 err_pre", {31'd0, err}, 32'd0);
        brn = 1; j = 1; target = 32'h700;
        tick(); expect_state("t5 illegal", 32'h2, 2'd0, 1'b0, 1'b0);
        check("t5 err_set", {31'd0, err}, 32'd1);
        idle();
        tick(); check("t5 err_sticky", {31'd0, err}, 32'd1);
        check("t5 pc", pc, 32'h3);

        // 6: reset aborts JM_WAIT; late mem_valid ignored
        jm = 1;
        tick(); expect_state("t6 wait", 32'h3, 2'd0, 1'b0, 1'b1);
        idle();
        tick();
        rst_n = 0;
        #1;
        expect_state("t6 async_rst", 32'h100, 2'd0, 1'b0, 1'b0);
        check("t6 err_clr", {31'd0, err}, 32'd0);
        tick();
        rst_n = 1; mem_valid = 1; mem_rdata = 32'hDEAD0000;
        tick(); expect_state("t6 ignore_mem", 32'h101, 2'd0, 1'b0, 1'b0);
        idle();

        // 6b: no-flush variant repeating test 2
        check("nf pc", pc0, 32'h101);
        flag_we = 1; alu_z = 1; brz = 1; target = 32'h40;
        tick();
        check("nf redirect pc", pc0, 32'h40);
        check("nf redirect src", {30'd0, pc_src0}, 32'd1);
        check("nf flush0", {31'd0, flush0}, 32'd0);
        idle();
        tick();
        check("nf seq pc", pc0, 32'h41);
        check("nf flush1", {31'd0, flush0}, 32'd0);
        tick();
        check("nf seq pc2", pc0, 32'h42);
        check("nf flush2", {31'd0, flush0}, 32'd0);
        j = 1; target = 32'hFFFFFFFF;
        tick();
        check("nf max", pc0, 32'hFFFFFFFF);
        idle();
        tick();
        check("nf run_wrap", pc0, 32'h0);
        check("nf run_wrap src", {30'd0, pc_src0}, 32'd0);
        jm = 1;
        tick();
        check("nf busy", {31'd0, busy0}, 32'd1);
        idle(); mem_valid = 1; mem_rdata = 32'h1234;
        tick();
        check("nf mem pc", pc0, 32'h1234);
        check("nf mem src", {30'd0, pc_src0}, 32'd2);
        check("nf mem flush", {31'd0, flush0}, 32'd0);
        check("nf mem busy", {31'd0, busy0}, 32'd0);
        idle();
        tick();
        check("nf after mem", pc0, 32'h1235);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
